mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
- Single owner of the tag's 16-bit SRAM macro (EPC, sensor-1 and sensor-2 banks).
- Arbitrates three requesters: reply-path reads (ACK/EPC read/sensor read), EPC writes (Write command) and ADC sensor-log writes.
- Sequences every access through the macro's precharge / wordline / sense-or-write phases.
- Sits between the command/sensor control logic and the memory macro pins.

Parameters:
- ADDR_W, 6, word address width (mem_address)
- DATA_W, 16, memory word width
- ACC_CYCLES, 1, cycles WE or SE stays high per access (1..4)
- STARVE_LIMIT, 4, consecutive services of other requesters with a sensor write pending before that write is forced

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rd_req  in  1  read request, level, held until rd_valid
- rd_sel  in  3  one-hot bank: 001 EPC, 010 sensor1, 100 sensor2
- rd_addr  in  ADDR_W  read word address
- rd_valid  out  1  one-cycle pulse: rd_data valid or rd_err set
- rd_data  out  DATA_W  captured read word, held until next read completes
- rd_err  out  1  with rd_valid: rd_sel not one-hot, no access performed
- epc_wr_req  in  1  EPC write request, level
- epc_wr_addr  in  ADDR_W  EPC word address
- epc_wr_data  in  DATA_W  EPC write word
- epc_wr_done  out  1  one-cycle completion pulse
- sns_wr_req  in  1  sensor write request, level
- sns_wr_sel  in  3  must be 010 or 100
- sns_wr_addr  in  ADDR_W  sensor log address
- sns_wr_data  in  DATA_W  {time_stamp, ADC_data}
- sns_wr_done  out  1  one-cycle completion pulse
- sns_wr_err  out  1  with sns_wr_done: illegal sns_wr_sel, no access
- mem_read_in  in  DATA_W  macro sense-amp output
- PC_B  out  1  precharge, active-low
- WE  out  1  write enable
- SE  out  1  sense enable
- mem_address  out  ADDR_W  wordline address
- mem_sel  out  3  one-hot bank select
- mem_data_out  out  DATA_W  write data
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: PC_B=1, WE=0, SE=0, mem_address=0, mem_sel=0, mem_data_out=0, rd_data=0, all pulses/err=0, busy=0, starvation counter=0, state IDLE. Reset aborts any in-flight access with no done/valid pulse; outputs take reset values on the next edge.
- States: IDLE -> PRE -> ACC -> REC -> IDLE.
- IDLE: evaluate requests; on a winner, latch its address, sel and data, drive mem_address/mem_sel, go to PRE.
- PRE (1 cycle): PC_B=0.
- ACC (ACC_CYCLES cycles): PC_B=1; WE=1 for a write, SE=1 for a read. On a read, rd_data <= mem_read_in at the last ACC cycle.
- REC (1 cycle): WE=SE=0; pulse the winner's done/valid.
- Latency: request seen in IDLE at cycle t -> done/valid at t+ACC_CYCLES+2. Back-to-back accesses cost one extra IDLE cycle.
- Priority: rd > epc_wr > sns_wr. Override: when starve_cnt==STARVE_LIMIT and sns_wr_req is high, sensor write wins.
- starve_cnt: increments on each grant to another requester while sns_wr_req is high; clears on a sensor grant or when sns_wr_req is low; saturates at STARVE_LIMIT.
- Illegal sel: the grant is decoded in IDLE and goes straight to REC (no PRE/ACC, macro pins untouched). The done/valid pulse carries err=1.
- Requests are levels. A requester deasserts its req in the cycle after its pulse or it is re-served. Inputs changing after the grant are ignored.
- mem_address, mem_sel and mem_data_out hold their last values in IDLE; only PC_B, WE and SE return to idle levels.
- Simultaneous requests arriving while busy are served in priority order after REC.

Decomposition:
- Package mem_arb_pkg: state encodings, MEM_SEL_EPC=3'b001, MEM_SEL_S1=3'b010, MEM_SEL_S2=3'b100, requester index constants.
- Sub-module mem_arb_prio: combinational priority pick plus the registered starvation counter; outputs a one-hot grant.

Test Plan:
- rd_req, rd_sel=001, rd_addr=5, mem_read_in=16'hA5C3 -> PC_B low 1 cycle, SE high 1 cycle, rd_valid at t+3 with rd_data=A5C3.
- rd_req and epc_wr_req (addr 2, data 16'h1234) asserted together -> read served first; EPC write follows after one IDLE cycle; WE high with mem_data_out=1234, mem_sel=001.
- rd_req held continuously with sns_wr_req high -> exactly 4 reads, then a sensor write (mem_sel=010), then reads resume.
- sns_wr_sel=011 -> sns_wr_done and sns_wr_err pulse 1 cycle after grant; PC_B, WE, SE never toggle.
- reset asserted during ACC of an EPC write -> WE=0 and PC_B=1 next cycle; no epc_wr_done pulse; state IDLE.
- ACC_CYCLES=3 read -> SE high exactly 3 cycles; rd_valid at t+5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and helpers for the SRAM access arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_ACC  = 2'd2,
    ST_REC  = 2'd3
  } state_t;

  localparam logic [2:0] MEM_SEL_EPC = 3'b001;
  localparam logic [2:0] MEM_SEL_S1  = 3'b010;
  localparam logic [2:0] MEM_SEL_S2  = 3'b100;

  localparam int REQ_RD  = 0;
  localparam int REQ_EPC = 1;
  localparam int REQ_SNS = 2;
  localparam int NUM_REQ = 3;

  function automatic logic sel_is_bank(input logic [2:0] sel);
    return (sel == MEM_SEL_EPC) || (sel == MEM_SEL_S1) || (sel == MEM_SEL_S2);
  endfunction

  function automatic logic sel_is_sensor(input logic [2:0] sel);
    return (sel == MEM_SEL_S1) || (sel == MEM_SEL_S2);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester handshakes and SRAM macro pins of the arbiter
interface mem_access_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) ();

  logic              rd_req;
  logic [2:0]        rd_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  logic              epc_wr_req;
  logic [ADDR_W-1:0] epc_wr_addr;
  logic [DATA_W-1:0] epc_wr_data;
  logic              epc_wr_done;

  logic              sns_wr_req;
  logic [2:0]        sns_wr_sel;
  logic [ADDR_W-1:0] sns_wr_addr;
  logic [DATA_W-1:0] sns_wr_data;
  logic              sns_wr_done;
  logic              sns_wr_err;

  logic [DATA_W-1:0] mem_read_in;
  logic              PC_B;
  logic              WE;
  logic              SE;
  logic [ADDR_W-1:0] mem_address;
  logic [2:0]        mem_sel;
  logic [DATA_W-1:0] mem_data_out;
  logic              busy;

  modport slave (
    input  rd_req, rd_sel, rd_addr,
    output rd_valid, rd_data, rd_err,
    input  epc_wr_req, epc_wr_addr, epc_wr_data,
    output epc_wr_done,
    input  sns_wr_req, sns_wr_sel, sns_wr_addr, sns_wr_data,
    output sns_wr_done, sns_wr_err,
    input  mem_read_in,
    output PC_B, WE, SE, mem_address, mem_sel, mem_data_out, busy
  );

  modport master (
    output rd_req, rd_sel, rd_addr,
    input  rd_valid, rd_data, rd_err,
    output epc_wr_req, epc_wr_addr, epc_wr_data,
    input  epc_wr_done,
    output sns_wr_req, sns_wr_sel, sns_wr_addr, sns_wr_data,
    input  sns_wr_done, sns_wr_err,
    output mem_read_in,
    input  PC_B, WE, SE, mem_address, mem_sel, mem_data_out, busy
  );

endinterface

// File: rtl/mem_arb_prio.sv
// rtl/mem_arb_prio.sv - fixed-priority pick with sensor-write starvation override
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant = '0;
    if (req[REQ_SNS] && starved) begin
      grant[REQ_SNS] = 1'b1;
    end else if (req[REQ_RD]) begin
      grant[REQ_RD] = 1'b1;
    end else if (req[REQ_EPC]) begin
      grant[REQ_EPC] = 1'b1;
    end else if (req[REQ_SNS]) begin
      grant[REQ_SNS] = 1'b1;
    end
  end

  // Only grants made while a sensor write waits count toward forcing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!req[REQ_SNS]) begin
      starve_cnt <= '0;
    end else if (take && (grant != '0)) begin
      if (grant[REQ_SNS]) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - sole owner of the SRAM macro; sequences precharge, access, recovery
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 16,
  parameter int ACC_CYCLES   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_arbiter_if.slave  bus
);

  localparam int ACC_W = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant;
  logic [NUM_REQ-1:0]  cur;
  logic                cur_err;
  logic [ACC_W-1:0]    acc_cnt;
  logic                acc_last;
  logic                take;

  logic [2:0]          win_sel;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_err;

  assign req      = {bus.sns_wr_req, bus.epc_wr_req, bus.rd_req};
  assign take     = (state == ST_IDLE);
  assign acc_last = (acc_cnt == ACC_W'(ACC_CYCLES - 1));

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .take  (take),
    .grant (grant)
  );

  always_comb begin
    win_sel  = '0;
    win_addr = '0;
    win_data = '0;
    win_err  = 1'b0;
    if (grant[REQ_RD]) begin
      win_sel  = bus.rd_sel;
      win_addr = bus.rd_addr;
      win_err  = !sel_is_bank(bus.rd_sel);
    end else if (grant[REQ_EPC]) begin
      win_sel  = MEM_SEL_EPC;
      win_addr = bus.epc_wr_addr;
      win_data = bus.epc_wr_data;
    end else if (grant[REQ_SNS]) begin
      win_sel  = bus.sns_wr_sel;
      win_addr = bus.sns_wr_addr;
      win_data = bus.sns_wr_data;
      win_err  = !sel_is_sensor(bus.sns_wr_sel);
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.PC_B        = 1'b1;
    bus.WE          = 1'b0;
    bus.SE          = 1'b0;
    bus.busy        = (state != ST_IDLE);
    bus.rd_valid    = 1'b0;
    bus.rd_err      = 1'b0;
    bus.epc_wr_done = 1'b0;
    bus.sns_wr_done = 1'b0;
    bus.sns_wr_err  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Illegal selects skip the macro entirely and only report the error.
        if (grant != '0) state_nxt = win_err ? ST_REC : ST_PRE;
      end
      ST_PRE: begin
        bus.PC_B  = 1'b0;
        state_nxt = ST_ACC;
      end
      ST_ACC: begin
        bus.SE = cur[REQ_RD];
        bus.WE = !cur[REQ_RD];
        if (acc_last) state_nxt = ST_REC;
      end
      ST_REC: begin
        bus.rd_valid    = cur[REQ_RD];
        bus.rd_err      = cur[REQ_RD] & cur_err;
        bus.epc_wr_done = cur[REQ_EPC];
        bus.sns_wr_done = cur[REQ_SNS];
        bus.sns_wr_err  = cur[REQ_SNS] & cur_err;
        state_nxt       = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      cur              <= '0;
      cur_err          <= 1'b0;
      acc_cnt          <= '0;
      bus.mem_address  <= '0;
      bus.mem_sel      <= '0;
      bus.mem_data_out <= '0;
      bus.rd_data      <= '0;
    end else begin
      state   <= state_nxt;
      acc_cnt <= (state == ST_ACC) ? acc_cnt + ACC_W'(1) : '0;
      if (take && (grant != '0)) begin
        cur     <= grant;
        cur_err <= win_err;
        if (!win_err) begin
          bus.mem_address <= win_addr;
          bus.mem_sel     <= win_sel;
          if (!grant[REQ_RD]) bus.mem_data_out <= win_data;
        end
      end
      if ((state == ST_ACC) && acc_last && cur[REQ_RD]) begin
        bus.rd_data <= bus.mem_read_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed scoreboard bench for mem_access_arbiter
module tb_mem_access_arbiter;
  import mem_arb_pkg::*;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_arbiter_if #(.ADDR_W(6), .DATA_W(16)) b0 ();
  mem_access_arbiter_if #(.ADDR_W(6), .DATA_W(16)) b1 ();

  mem_access_arbiter #(.ADDR_W(6), .DATA_W(16), .ACC_CYCLES(1), .STARVE_LIMIT(4)) dut0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  mem_access_arbiter #(.ADDR_W(6), .DATA_W(16), .ACC_CYCLES(3), .STARVE_LIMIT(4)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  int vec = 0;
  int miss = 0;

  rd_exp_t     q_rd0[$];
  rd_exp_t     q_rd1[$];
  logic        q_epc[$];
  logic        q_sns[$];
  logic [24:0] q_wr[$];

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a response or starts a write.
  rd_exp_t     e0, e1;
  logic        eb;
  logic [24:0] ew;
  logic        we0_q = 1'b0;
  always @(negedge clk) begin
    if (b0.rd_valid === 1'b1) begin
      if (q_rd0.size() == 0) chk("rd0_unexpected", 1, 0);
      else begin
        e0 = q_rd0.pop_front();
        chk("rd0_data", int'(b0.rd_data), int'(e0.data));
        chk("rd0_err", int'(b0.rd_err), int'(e0.err));
      end
    end
    if (b1.rd_valid === 1'b1) begin
      if (q_rd1.size() == 0) chk("rd1_unexpected", 1, 0);
      else begin
        e1 = q_rd1.pop_front();
        chk("rd1_data", int'(b1.rd_data), int'(e1.data));
        chk("rd1_err", int'(b1.rd_err), int'(e1.err));
      end
    end
    if (b0.epc_wr_done === 1'b1) begin
      if (q_epc.size() == 0) chk("epc_unexpected", 1, 0);
      else begin
        eb = q_epc.pop_front();
        chk("epc_done_err", 0, int'(eb));
      end
    end
    if (b0.sns_wr_done === 1'b1) begin
      if (q_sns.size() == 0) chk("sns_unexpected", 1, 0);
      else begin
        eb = q_sns.pop_front();
        chk("sns_err", int'(b0.sns_wr_err), int'(eb));
      end
    end
    if ((b0.WE === 1'b1) && (we0_q !== 1'b1)) begin
      if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        ew = q_wr.pop_front();
        chk("wr_word", int'({b0.mem_sel, b0.mem_address, b0.mem_data_out}), int'(ew));
      end
    end
    we0_q <= b0.WE;
  end

  task automatic wait_done(input int dut, input int kind, output int lat,
                           output int pcb_lo, output int we_hi, output int se_hi);
    logic p;
    lat = -1; pcb_lo = 0; we_hi = 0; se_hi = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (dut == 0) begin
        pcb_lo += int'(b0.PC_B == 1'b0);
        we_hi  += int'(b0.WE == 1'b1);
        se_hi  += int'(b0.SE == 1'b1);
        p = (kind == 0) ? b0.rd_valid : (kind == 1) ? b0.epc_wr_done : b0.sns_wr_done;
      end else begin
        pcb_lo += int'(b1.PC_B == 1'b0);
        we_hi  += int'(b1.WE == 1'b1);
        se_hi  += int'(b1.SE == 1'b1);
        p = b1.rd_valid;
      end
      if (p === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat, pcb, weh, seh;
  int nrd, np, sns_pos;
  logic drop_sns;

  initial begin
    b0.rd_req = 0; b0.rd_sel = 0; b0.rd_addr = 0;
    b0.epc_wr_req = 0; b0.epc_wr_addr = 0; b0.epc_wr_data = 0;
    b0.sns_wr_req = 0; b0.sns_wr_sel = 0; b0.sns_wr_addr = 0; b0.sns_wr_data = 0;
    b0.mem_read_in = 0;
    b1.rd_req = 0; b1.rd_sel = 0; b1.rd_addr = 0;
    b1.epc_wr_req = 0; b1.epc_wr_addr = 0; b1.epc_wr_data = 0;
    b1.sns_wr_req = 0; b1.sns_wr_sel = 0; b1.sns_wr_addr = 0; b1.sns_wr_data = 0;
    b1.mem_read_in = 0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc_b", int'(b0.PC_B), 1);
    chk("rst_we", int'(b0.WE), 0);
    chk("rst_se", int'(b0.SE), 0);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_addr", int'(b0.mem_address), 0);
    chk("rst_sel", int'(b0.mem_sel), 0);
    chk("rst_dout", int'(b0.mem_data_out), 0);
    chk("rst_rd_data", int'(b0.rd_data), 0);
    chk("rst_rd_valid", int'(b0.rd_valid), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single EPC read
    b0.mem_read_in = 16'hA5C3;
    b0.rd_sel = 3'b001; b0.rd_addr = 6'd5; b0.rd_req = 1'b1;
    q_rd0.push_back('{data: 16'hA5C3, err: 1'b0});
    wait_done(0, 0, lat, pcb, weh, seh);
    chk("t1_latency", lat, 3);
    chk("t1_pc_b_low", pcb, 1);
    chk("t1_se_high", seh, 1);
    chk("t1_we_high", weh, 0);
    chk("t1_mem_addr", int'(b0.mem_address), 5);
    chk("t1_mem_sel", int'(b0.mem_sel), 1);
    @(posedge clk); #1;
    b0.rd_req = 1'b0;

    // Read and EPC write together
    b0.mem_read_in = 16'h3C3C;
    b0.rd_sel = 3'b001; b0.rd_addr = 6'd8; b0.rd_req = 1'b1;
    b0.epc_wr_addr = 6'd2; b0.epc_wr_data = 16'h1234; b0.epc_wr_req = 1'b1;
    q_rd0.push_back('{data: 16'h3C3C, err: 1'b0});
    q_epc.push_back(1'b0);
    q_wr.push_back({3'b001, 6'd2, 16'h1234});
    wait_done(0, 0, lat, pcb, weh, seh);
    chk("t2_rd_latency", lat, 3);
    chk("t2_rd_no_we", weh, 0);
    @(posedge clk); #1;
    b0.rd_req = 1'b0;
    wait_done(0, 1, lat, pcb, weh, seh);
    chk("t2_wr_latency", lat, 3);
    chk("t2_we_high", weh, 1);
    chk("t2_se_high", seh, 0);
    @(posedge clk); #1;
    b0.epc_wr_req = 1'b0;

    // Continuous reads starve a sensor write until the override
    b0.mem_read_in = 16'h1111;
    b0.rd_sel = 3'b010; b0.rd_addr = 6'd7; b0.rd_req = 1'b1;
    b0.sns_wr_sel = 3'b010; b0.sns_wr_addr = 6'd9; b0.sns_wr_data = 16'hBEEF; b0.sns_wr_req = 1'b1;
    for (int i = 0; i < 6; i++) q_rd0.push_back('{data: 16'h1111, err: 1'b0});
    q_sns.push_back(1'b0);
    q_wr.push_back({3'b010, 6'd9, 16'hBEEF});
    nrd = 0; np = 0; sns_pos = -1; drop_sns = 1'b0;
    for (int n = 0; n < 200 && np < 7; n++) begin
      @(posedge clk); #1;
      if (drop_sns) begin
        b0.sns_wr_req = 1'b0;
        drop_sns = 1'b0;
      end
      if (b0.rd_valid === 1'b1) begin
        nrd++; np++;
      end
      if (b0.sns_wr_done === 1'b1) begin
        sns_pos = np; np++; drop_sns = 1'b1;
      end
    end
    @(posedge clk); #1;
    b0.rd_req = 1'b0;
    b0.sns_wr_req = 1'b0;
    chk("t3_sns_position", sns_pos, 4);
    chk("t3_read_count", nrd, 6);

    // Illegal sensor select: error pulse, macro pins untouched
    b0.sns_wr_sel = 3'b011; b0.sns_wr_addr = 6'd3; b0.sns_wr_data = 16'h0; b0.sns_wr_req = 1'b1;
    q_sns.push_back(1'b1);
    wait_done(0, 2, lat, pcb, weh, seh);
    chk("t4_latency", lat, 1);
    chk("t4_pc_b_low", pcb, 0);
    chk("t4_we_high", weh, 0);
    chk("t4_se_high", seh, 0);
    chk("t4_addr_held", int'(b0.mem_address), 7);
    chk("t4_sel_held", int'(b0.mem_sel), 2);
    @(posedge clk); #1;
    b0.sns_wr_req = 1'b0;

    // Illegal read select: error, rd_data keeps previous word
    b0.mem_read_in = 16'h2222;
    b0.rd_sel = 3'b110; b0.rd_addr = 6'd1; b0.rd_req = 1'b1;
    q_rd0.push_back('{data: 16'h1111, err: 1'b1});
    wait_done(0, 0, lat, pcb, weh, seh);
    chk("t4r_latency", lat, 1);
    chk("t4r_se_high", seh, 0);
    @(posedge clk); #1;
    b0.rd_req = 1'b0;

    // Reset during ACC of an EPC write
    b0.epc_wr_addr = 6'd4; b0.epc_wr_data = 16'h5678; b0.epc_wr_req = 1'b1;
    q_wr.push_back({3'b001, 6'd4, 16'h5678});
    @(posedge clk); #1;
    chk("t5_pre_pc_b", int'(b0.PC_B), 0);
    @(posedge clk); #1;
    chk("t5_acc_we", int'(b0.WE), 1);
    reset = 1'b1;
    b0.epc_wr_req = 1'b0;
    @(posedge clk); #1;
    chk("t5_we_after_rst", int'(b0.WE), 0);
    chk("t5_pc_b_after_rst", int'(b0.PC_B), 1);
    chk("t5_busy_after_rst", int'(b0.busy), 0);
    chk("t5_done_after_rst", int'(b0.epc_wr_done), 0);
    chk("t5_addr_after_rst", int'(b0.mem_address), 0);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_idle", int'(b0.busy), 0);

    // Three-cycle access on the second instance
    b1.mem_read_in = 16'h0F0F;
    b1.rd_sel = 3'b100; b1.rd_addr = 6'd12; b1.rd_req = 1'b1;
    q_rd1.push_back('{data: 16'h0F0F, err: 1'b0});
    wait_done(1, 0, lat, pcb, weh, seh);
    chk("t6_latency", lat, 5);
    chk("t6_se_high", seh, 3);
    chk("t6_pc_b_low", pcb, 1);
    chk("t6_mem_sel", int'(b1.mem_sel), 4);
    chk("t6_mem_addr", int'(b1.mem_address), 12);
    @(posedge clk); #1;
    b1.rd_req = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    chk("q_rd0_left", q_rd0.size(), 0);
    chk("q_rd1_left", q_rd1.size(), 0);
    chk("q_epc_left", q_epc.size(), 0);
    chk("q_sns_left", q_sns.size(), 0);
    chk("q_wr_left", q_wr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
